// File: rtl/oh_clkgate_ctrl_if.sv
// Request/grant bundle between the requesters and the shared clock-gate controller.
// The master side issues req/force_on; the slave (controller) returns ack, clken and state.
interface oh_clkgate_ctrl_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic         force_on;
  logic [N-1:0] ack;
  logic         clken;
  logic [1:0]   state;

  modport master (
    output req,
    output force_on,
    input  ack,
    input  clken,
    input  state
  );

  modport slave (
    input  req,
    input  force_on,
    output ack,
    output clken,
    output state
  );
endinterface

// File: rtl/oh_clkgate_ctrl.sv
// Clock-enable controller for one gated clock branch shared by N requesters:
// wake-up settle before granting, idle hysteresis before gating off.
module oh_clkgate_ctrl #(
  parameter int N       = 4,
  parameter int WAKECNT = 2,
  parameter int IDLECNT = 16,
  parameter     PROP    = "DEFAULT"
) (
  input  logic              clk,
  input  logic              nreset,
  oh_clkgate_ctrl_if.slave  bus
);

  localparam int MAXC = (WAKECNT > IDLECNT) ? WAKECNT : IDLECNT;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

  localparam logic [CW-1:0] WAKE_LD = CW'(WAKECNT);
  localparam logic [CW-1:0] IDLE_LD = CW'(IDLECNT);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {
    S_OFF  = 2'b00,
    S_WAKE = 2'b01,
    S_ON   = 2'b10,
    S_HOLD = 2'b11
  } state_e;

  // The property string only tags the instance; it does not alter behaviour.
  if (PROP != "DEFAULT") begin : g_prop_custom
  end

  state_e         state_q;
  logic           clken_q;
  logic [N-1:0]   ack_q;
  logic [CW-1:0]  cnt_q;

  logic any;
  assign any = (|bus.req) | bus.force_on;

  // NOTE: every output is a flop; ack is never a combinational function of req,
  // so the ICG enable and the grants cannot glitch.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_OFF;
      clken_q <= 1'b0;
      ack_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so all decisions in this edge
      // see the pre-edge values of state/counter.
      case (state_q)
        S_OFF: begin
          ack_q <= '0;
          if (any) begin
            clken_q <= 1'b1;
            if (WAKECNT == 0) begin
              state_q <= S_ON;
              ack_q   <= bus.req;
            end else begin
              state_q <= S_WAKE;
              cnt_q   <= WAKE_LD;
            end
          end
        end

        S_WAKE: begin
          // Wake-up is never aborted: the branch must settle before any decision.
          if (cnt_q == ONE) begin
            if (any) begin
              state_q <= S_ON;
              ack_q   <= bus.req;
            end else if (IDLECNT == 0) begin
              state_q <= S_OFF;
              clken_q <= 1'b0;
            end else begin
              state_q <= S_HOLD;
              cnt_q   <= IDLE_LD;
            end
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end

        S_ON: begin
          ack_q <= bus.req;
          if (!any) begin
            ack_q <= '0;
            if (IDLECNT == 0) begin
              state_q <= S_OFF;
              clken_q <= 1'b0;
            end else begin
              state_q <= S_HOLD;
              cnt_q   <= IDLE_LD;
            end
          end
        end

        S_HOLD: begin
          // A new request wins over counter expiry; the clock never stopped.
          if (any) begin
            state_q <= S_ON;
            ack_q   <= bus.req;
          end else if (cnt_q == ONE) begin
            state_q <= S_OFF;
            clken_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end

        default: begin
          state_q <= S_OFF;
          clken_q <= 1'b0;
          ack_q   <= '0;
        end
      endcase
    end
  end

  assign bus.ack   = ack_q;
  assign bus.clken = clken_q;
  assign bus.state = state_q;

endmodule
